// File: rtl/ahb_pkg.sv
// Shared AHB-Lite constants and the SRAM controller FSM encoding.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE  = 3'd0;
   localparam logic [2:0] HSIZE_HALF  = 3'd1;
   localparam logic [2:0] HSIZE_WORD  = 3'd2;
   localparam logic [2:0] HSIZE_DWORD = 3'd3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_ERR1    = 2'd2,
      ST_ERR2    = 2'd3
   } sram_state_e;

endpackage

// File: rtl/ahb_sram_ctrl_if.sv
// AHB-Lite slave-side signal bundle for the SRAM controller.
interface ahb_sram_ctrl_if #(
   parameter int AWIDTH = 32,
   parameter int DWIDTH = 32
);
   logic              hsel_i;
   logic              hwrite_i;
   logic              hready_i;
   logic [2:0]        hsize_i;
   logic [2:0]        hburst_i;
   logic [1:0]        htrans_i;
   logic [AWIDTH-1:0] haddr_i;
   logic [DWIDTH-1:0] hwdata_i;
   logic              hreadyout_o;
   logic              hresp_o;
   logic [DWIDTH-1:0] hrdata_o;

   modport master (
      output hsel_i, hwrite_i, hready_i, hsize_i, hburst_i, htrans_i, haddr_i, hwdata_i,
      input  hreadyout_o, hresp_o, hrdata_o
   );

   modport slave (
      input  hsel_i, hwrite_i, hready_i, hsize_i, hburst_i, htrans_i, haddr_i, hwdata_i,
      output hreadyout_o, hresp_o, hrdata_o
   );
endinterface

// File: rtl/ahb_sram_ctrl_sram_bank.sv
// Single-port synchronous SRAM bank: per-byte write enable, registered read
// output that holds its value until the next read.
module sram_bank #(
   parameter int DWIDTH = 32,
   parameter int DEPTH  = 8192
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       en_i,
   input  logic [DWIDTH/8-1:0]        we_i,
   input  logic [$clog2(DEPTH)-1:0]   addr_i,
   input  logic [DWIDTH-1:0]          wdata_i,
   output logic [DWIDTH-1:0]          rdata_o
);

   logic [DWIDTH-1:0] mem [DEPTH];
   logic [DWIDTH-1:0] rdata_q, rdata_d;

   always_comb begin
      rdata_d = rdata_q;
      if (en_i && (we_i == '0)) rdata_d = mem[addr_i];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdata_q <= '0;
      else        rdata_q <= rdata_d;
   end

   always_ff @(posedge clk) begin
      if (en_i) begin
         for (int i = 0; i < DWIDTH/8; i++) begin
            if (we_i[i]) mem[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/ahb_sram_ctrl.sv
// AHB-Lite SRAM slave: banked single-port array, data-phase writes, one wait
// state on read-after-write collision. Define AHB_SRAM_ERR_EN for ERROR responses.
module ahb_sram_ctrl
   import ahb_pkg::*;
#(
   parameter int AWIDTH     = 32,
   parameter int DWIDTH     = 32,
   parameter int NBANKS     = 2,
   parameter int BANK_DEPTH = 8192
) (
   input  logic            hclk,
   input  logic            hresetn,
   ahb_sram_ctrl_if.slave  bus
);

   localparam int NBYTES = DWIDTH / 8;
   localparam int ABITS  = $clog2(NBYTES);
   localparam int ROW_W  = $clog2(BANK_DEPTH);
   localparam int BSEL_W = $clog2(NBANKS);
   localparam int BANK_W = (NBANKS > 1) ? BSEL_W : 1;
   localparam int WORD_W = ROW_W + BSEL_W;
   localparam int OFF_W  = ABITS + WORD_W;
   localparam logic [2:0] MAX_SIZE = (DWIDTH == 64) ? HSIZE_DWORD : HSIZE_WORD;

   // Oversize transfers collapse to full width; the lane base is aligned down to the size.
   function automatic logic [NBYTES-1:0] lane_mask(input logic [2:0] size,
                                                   input logic [ABITS-1:0] lo);
      logic [2:0]        sz;
      logic [ABITS-1:0]  base;
      logic [NBYTES-1:0] m;
      sz   = (size > MAX_SIZE) ? MAX_SIZE : size;
      base = lo & ~ABITS'((1 << sz) - 1);
      m    = NBYTES'((1 << (1 << sz)) - 1);
      return m << base;
   endfunction

   logic              accept, is_err;
   logic [WORD_W-1:0] a_word;
   logic [BANK_W-1:0] a_bank;
   logic [ROW_W-1:0]  a_row;
   logic [NBYTES-1:0] a_lanes;

   assign accept  = bus.hsel_i & bus.hready_i & bus.htrans_i[1];
   assign a_word  = bus.haddr_i[OFF_W-1:ABITS];
   assign a_row   = a_word[ROW_W-1:0];
   assign a_bank  = BANK_W'(a_word >> ROW_W);
   assign a_lanes = lane_mask(bus.hsize_i, bus.haddr_i[ABITS-1:0]);

   sram_state_e       state_q, state_d;
   logic              hreadyout_q, hreadyout_d;
   logic              hresp_q, hresp_d;
   logic              wr_pend_q, wr_pend_d;
   logic [BANK_W-1:0] wr_bank_q, wr_bank_d;
   logic [ROW_W-1:0]  wr_row_q, wr_row_d;
   logic [NBYTES-1:0] wr_lanes_q, wr_lanes_d;
   logic [BANK_W-1:0] rd_bank_q, rd_bank_d;
   logic [ROW_W-1:0]  rd_row_q, rd_row_d;
   logic [BANK_W-1:0] rd_sel_q, rd_sel_d;

   logic              op_en, op_write;
   logic [BANK_W-1:0] op_bank;
   logic [ROW_W-1:0]  op_row;
   logic              unused;

`ifdef AHB_SRAM_ERR_EN
   assign is_err = accept & ((|bus.haddr_i[AWIDTH-1:OFF_W]) | (bus.hsize_i > MAX_SIZE));
   assign unused = ^{bus.hburst_i};
`else
   assign is_err = 1'b0;
   assign unused = ^{bus.hburst_i, bus.haddr_i[AWIDTH-1:OFF_W], hresp_q};
`endif

   always_comb begin
      state_d     = ST_IDLE;
      hreadyout_d = 1'b1;
      hresp_d     = 1'b0;
      wr_pend_d   = 1'b0;
      wr_bank_d   = wr_bank_q;
      wr_row_d    = wr_row_q;
      wr_lanes_d  = wr_lanes_q;
      rd_bank_d   = rd_bank_q;
      rd_row_d    = rd_row_q;
      rd_sel_d    = rd_sel_q;
      op_en       = 1'b0;
      op_write    = 1'b0;
      op_bank     = wr_bank_q;
      op_row      = wr_row_q;

      // A completing write data phase owns the port; a held read goes next.
      if (wr_pend_q) begin
         op_en    = 1'b1;
         op_write = 1'b1;
      end else if (state_q == ST_RD_WAIT) begin
         op_en    = 1'b1;
         op_bank  = rd_bank_q;
         op_row   = rd_row_q;
         rd_sel_d = rd_bank_q;
      end

      if (accept && !is_err) begin
         if (bus.hwrite_i) begin
            wr_pend_d  = 1'b1;
            wr_bank_d  = a_bank;
            wr_row_d   = a_row;
            wr_lanes_d = a_lanes;
         end else if (wr_pend_q) begin
            rd_bank_d   = a_bank;
            rd_row_d    = a_row;
            state_d     = ST_RD_WAIT;
            hreadyout_d = 1'b0;
         end else begin
            op_en    = 1'b1;
            op_bank  = a_bank;
            op_row   = a_row;
            rd_sel_d = a_bank;
         end
      end

`ifdef AHB_SRAM_ERR_EN
      if (is_err) begin
         state_d     = ST_ERR1;
         hreadyout_d = 1'b0;
         hresp_d     = 1'b1;
      end
      if (state_q == ST_ERR1) begin
         state_d     = ST_ERR2;
         hreadyout_d = 1'b1;
         hresp_d     = 1'b1;
      end
`endif
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state_q     <= ST_IDLE;
         hreadyout_q <= 1'b1;
         hresp_q     <= 1'b0;
         wr_pend_q   <= 1'b0;
         rd_sel_q    <= '0;
      end else begin
         state_q     <= state_d;
         hreadyout_q <= hreadyout_d;
         hresp_q     <= hresp_d;
         wr_pend_q   <= wr_pend_d;
         rd_sel_q    <= rd_sel_d;
      end
   end

   always_ff @(posedge hclk) begin
      wr_bank_q  <= wr_bank_d;
      wr_row_q   <= wr_row_d;
      wr_lanes_q <= wr_lanes_d;
      rd_bank_q  <= rd_bank_d;
      rd_row_q   <= rd_row_d;
   end

   logic [DWIDTH-1:0] bank_rdata [NBANKS];

   for (genvar b = 0; b < NBANKS; b++) begin : g_bank
      sram_bank #(
         .DWIDTH (DWIDTH),
         .DEPTH  (BANK_DEPTH)
      ) u_bank (
         .clk     (hclk),
         .rst_n   (hresetn),
         .en_i    (op_en && (op_bank == BANK_W'(b))),
         .we_i    (op_write ? wr_lanes_q : '0),
         .addr_i  (op_row),
         .wdata_i (bus.hwdata_i),
         .rdata_o (bank_rdata[b])
      );
   end

   assign bus.hrdata_o    = bank_rdata[rd_sel_q];
   assign bus.hreadyout_o = hreadyout_q;
`ifdef AHB_SRAM_ERR_EN
   assign bus.hresp_o     = hresp_q;
`else
   assign bus.hresp_o     = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Scoreboard bench for ahb_sram_ctrl: directed AHB-Lite transfers, expectations
// queued at issue time and checked by an independent data-phase monitor.
module tb_ahb_sram_ctrl;
   import ahb_pkg::*;

   logic hclk = 1'b0;
   logic hresetn;
   always #5 hclk = ~hclk;

   ahb_sram_ctrl_if #(.AWIDTH(32), .DWIDTH(32)) bus ();
   assign bus.hready_i = bus.hreadyout_o;

   ahb_sram_ctrl #(
      .AWIDTH     (32),
      .DWIDTH     (32),
      .NBANKS     (2),
      .BANK_DEPTH (8192)
   ) dut (
      .hclk    (hclk),
      .hresetn (hresetn),
      .bus     (bus)
   );

   typedef struct {
      logic        rd;
      logic [31:0] data;
      int          waits;
      logic        resp;
      int          id;
   } exp_t;

   typedef struct {
      logic [1:0]  trans;
      logic        wr;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      exp_t        e;
   } stim_t;

   exp_t  exp_q[$];
   stim_t stim_q[$];
   int    n_cmp = 0;
   int    n_bad = 0;
   int    n_id  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, want);
      end
   endtask

   task automatic add(input logic [1:0] tr, input logic w, input logic [2:0] sz,
                      input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdv,
                      input int wt, input logic rsp);
      stim_t s;
      s.trans   = tr;
      s.wr      = w;
      s.size    = sz;
      s.addr    = a;
      s.wdata   = wd;
      s.e.rd    = ~w;
      s.e.data  = rdv;
      s.e.waits = wt;
      s.e.resp  = rsp;
      s.e.id    = n_id;
      n_id++;
      stim_q.push_back(s);
   endtask

   task automatic do_wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
      add(HTRANS_NONSEQ, 1'b1, sz, a, wd, 32'h0, 0, 1'b0);
   endtask

   task automatic do_rd(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] rdv,
                        input int wt, input logic rsp);
      add(HTRANS_NONSEQ, 1'b0, sz, a, 32'h0, rdv, wt, rsp);
   endtask

   task automatic do_idle();
      add(HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0, 32'h0, 32'h0, 0, 1'b0);
   endtask

   task automatic do_busy();
      add(HTRANS_BUSY, 1'b1, HSIZE_WORD, 32'h10, 32'h0, 32'h0, 0, 1'b0);
   endtask

   // Advance to the edge that ends the current data phase (HREADY high).
   task automatic step_until_ready();
      int   n;
      logic rdy;
      n = 0;
      do begin
         @(negedge hclk);
         rdy = bus.hreadyout_o;
         @(posedge hclk);
         #1;
         n++;
      end while (!rdy && n < 20);
      if (!rdy) begin
         n_cmp++;
         n_bad++;
         $display("FAIL ready_timeout: got hreadyout=0 for %0d cycles, want 1", n);
      end
   endtask

   task automatic run_seq();
      logic [31:0] dp_wdata;
      stim_t       s;
      dp_wdata = '0;
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         bus.hsel_i   = (s.trans != HTRANS_IDLE);
         bus.htrans_i = s.trans;
         bus.hwrite_i = s.wr;
         bus.hsize_i  = s.size;
         bus.haddr_i  = s.addr;
         bus.hburst_i = 3'b000;
         bus.hwdata_i = dp_wdata;
         if (s.trans[1]) exp_q.push_back(s.e);
         step_until_ready();
         dp_wdata = (s.trans[1] && s.wr) ? s.wdata : 32'h0;
      end
      bus.hsel_i   = 1'b0;
      bus.htrans_i = HTRANS_IDLE;
      bus.hwrite_i = 1'b0;
      bus.hwdata_i = dp_wdata;
      step_until_ready();
      bus.hwdata_i = '0;
      repeat (2) @(posedge hclk);
      #1;
   endtask

   // Monitor: tracks each accepted transfer through its data phase.
   logic in_dp = 1'b0;
   logic dp_first;
   logic dp_resp_first;
   int   dp_waits;

   always @(negedge hclk) begin
      exp_t e;
      if (!hresetn) begin
         in_dp = 1'b0;
      end else begin
         if (in_dp) begin
            if (dp_first) begin
               dp_resp_first = bus.hresp_o;
               dp_first      = 1'b0;
            end
            if (!bus.hreadyout_o) begin
               dp_waits++;
            end else begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_response: got a data phase, want none queued");
               end else begin
                  e = exp_q.pop_front();
                  check($sformatf("waits[%0d]", e.id), 32'(dp_waits), 32'(e.waits));
                  check($sformatf("resp_first[%0d]", e.id), {31'b0, dp_resp_first}, {31'b0, e.resp});
                  check($sformatf("resp_last[%0d]", e.id), {31'b0, bus.hresp_o}, {31'b0, e.resp});
                  if (e.rd && !e.resp)
                     check($sformatf("rdata[%0d]", e.id), bus.hrdata_o, e.data);
               end
               in_dp = 1'b0;
            end
         end
         if (bus.hsel_i && bus.hready_i && bus.htrans_i[1]) begin
            in_dp    = 1'b1;
            dp_first = 1'b1;
            dp_waits = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by time limit, want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      hresetn      = 1'b0;
      bus.hsel_i   = 1'b0;
      bus.hwrite_i = 1'b0;
      bus.hsize_i  = HSIZE_WORD;
      bus.hburst_i = 3'b000;
      bus.htrans_i = HTRANS_IDLE;
      bus.haddr_i  = '0;
      bus.hwdata_i = '0;
      repeat (3) @(negedge hclk);
      check("reset_hreadyout", {31'b0, bus.hreadyout_o}, 32'h1);
      check("reset_hresp", {31'b0, bus.hresp_o}, 32'h0);
      check("reset_hrdata", bus.hrdata_o, 32'h0);
      @(posedge hclk);
      #1;
      hresetn = 1'b1;
      @(posedge hclk);
      #1;

      // Write, idle, read: zero wait on both.
      do_wr(32'h10, HSIZE_WORD, 32'hDEADBEEF);
      do_idle();
      do_rd(32'h10, HSIZE_WORD, 32'hDEADBEEF, 0, 1'b0);
      // Read straight after write: one wait state.
      do_wr(32'h20, HSIZE_WORD, 32'h11223344);
      do_rd(32'h20, HSIZE_WORD, 32'h11223344, 1, 1'b0);
      // Byte and halfword lanes over a zeroed word.
      do_wr(32'h40, HSIZE_WORD, 32'h00000000);
      do_idle();
      do_wr(32'h41, HSIZE_BYTE, 32'h0000AA00);
      do_wr(32'h42, HSIZE_HALF, 32'hBBCC0000);
      do_rd(32'h40, HSIZE_WORD, 32'hBBCCAA00, 1, 1'b0);
      // Bank 1 first word versus bank 0 row 0.
      do_wr(32'h0, HSIZE_WORD, 32'h01020304);
      do_idle();
      do_wr(32'h8000, HSIZE_WORD, 32'h5A5A5A5A);
      do_idle();
      do_rd(32'h8000, HSIZE_WORD, 32'h5A5A5A5A, 0, 1'b0);
      do_rd(32'h0, HSIZE_WORD, 32'h01020304, 0, 1'b0);
      do_idle();
`ifdef AHB_SRAM_ERR_EN
      do_rd(32'h10000, HSIZE_WORD, 32'h0, 1, 1'b1);
      do_idle();
      do_rd(32'h10, HSIZE_DWORD, 32'h0, 1, 1'b1);
      do_idle();
`else
      do_rd(32'h10000, HSIZE_WORD, 32'h01020304, 0, 1'b0);
      do_idle();
      do_rd(32'h10, HSIZE_DWORD, 32'hDEADBEEF, 0, 1'b0);
      do_idle();
`endif
      // Misaligned halfword aligns down to 0x10; BUSY must not touch the array.
      do_wr(32'h11, HSIZE_HALF, 32'h00007777);
      do_busy();
      do_rd(32'h10, HSIZE_WORD, 32'hDEADF00D & 32'hFFFF0000 | 32'h00007777, 0, 1'b0);
      run_seq();

      // Reset in the middle of a write data phase: write must be discarded.
      bus.hsel_i   = 1'b1;
      bus.htrans_i = HTRANS_NONSEQ;
      bus.hwrite_i = 1'b1;
      bus.hsize_i  = HSIZE_WORD;
      bus.haddr_i  = 32'h10;
      bus.hwdata_i = '0;
      step_until_ready();
      bus.hsel_i   = 1'b0;
      bus.htrans_i = HTRANS_IDLE;
      bus.hwrite_i = 1'b0;
      bus.hwdata_i = 32'hCAFEF00D;
      hresetn      = 1'b0;
      @(negedge hclk);
      check("midreset_hreadyout", {31'b0, bus.hreadyout_o}, 32'h1);
      check("midreset_hresp", {31'b0, bus.hresp_o}, 32'h0);
      check("midreset_hrdata", bus.hrdata_o, 32'h0);
      repeat (2) @(posedge hclk);
      #1;
      bus.hwdata_i = '0;
      hresetn      = 1'b1;
      @(posedge hclk);
      #1;
      do_rd(32'h10, HSIZE_WORD, 32'hDEAD7777, 0, 1'b0);
      run_seq();

      check("leftover_expectations", 32'(exp_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
